seg_scan_scheduler: RTL and testbench

Time-multiplexing scheduler for the 8-digit seven-segment display. It holds a double-buffered digit register file that writers load through a valid/ready port and commit atomically at frame boundaries. It walks the anodes with a per-slot blanking interval to suppress ghosting, and applies per-slot enable, blanking and leading-zero suppression. Its `AN` and `digit` outputs drive the anode pins and the BCD-to-cathode decoder directly, replacing a free-running refresh counter.

---
 rtl/seg_scan_scheduler.sv | 175 +++++++++++++++++
 tb/tb_seg_scan_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_scheduler.sv
// seg_scan_scheduler: anode scan scheduler for an up-to-8-digit seven-segment
// display. Double-buffered digit registers (shadow written via valid/ready,
// copied to active atomically at the frame wrap), per-slot blanking interval
// against ghosting, per-slot enable / force-blank / leading-zero suppression.
// Optional feature: define SEG_SCAN_DIM_EN to add the 2-bit `dim` input that
// shortens the lit part of each SHOW window to (dim+1)/4 of its length.
module seg_scan_scheduler #(
  parameter int DIGITS       = 8,
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic       commit,
  output logic       commit_done,
  input  logic [7:0] enable_mask,
  input  logic       lz_suppress,
`ifdef SEG_SCAN_DIM_EN
  input  logic [1:0] dim,
`endif
  output logic [7:0] AN,
  output logic [3:0] digit,
  output logic       digit_blank,
  output logic [2:0] slot_idx,
  output logic       frame_done
);

  localparam int CW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SHOW_LEN = TICK_DIV - BLANK_CYCLES;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_LEN - 1);
  localparam logic [2:0]    SLOT_LAST  = 3'(DIGITS - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t               state_q, state_d;
  logic [2:0]           slot_q, slot_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 frame_done_q, frame_done_d;
  logic                 pending_q, pending_d;
  logic                 commit_done_q, commit_done_d;
  logic [DIGITS-1:0][4:0] shadow_q, shadow_d;
  logic [DIGITS-1:0][4:0] active_q, active_d;
  logic [7:0]           an_q, an_d;
  logic [3:0]           digit_q, digit_d;
  logic                 blank_q, blank_d;

  logic                 do_copy;
  logic [DIGITS-1:0]    supp;
  logic                 zero_run;
  logic [4:0]           sel_data;
  logic                 sel_supp;
  logic                 window_lit;
  logic                 lit;

  // Slot/phase sequencer: BLANK then SHOW per slot, wrap after the last slot.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    cnt_d        = cnt_q + 1'b1;
    frame_done_d = 1'b0;
    if (!run) begin
      state_d = BLANK;
      slot_d  = 3'd0;
      cnt_d   = '0;
    end else if (state_q == BLANK) begin
      if (cnt_q == BLANK_LAST) begin
        state_d = SHOW;
        cnt_d   = '0;
      end
    end else if (cnt_q == SHOW_LAST) begin
      state_d = BLANK;
      cnt_d   = '0;
      if (slot_q == SLOT_LAST) begin
        slot_d       = 3'd0;
        frame_done_d = 1'b1;
      end else begin
        slot_d = slot_q + 3'd1;
      end
    end
  end

  // Shadow writes and the shadow->active copy; while a commit is pending the
  // write port is closed so the snapshot stays exactly what was committed.
  always_comb begin
    shadow_d      = shadow_q;
    active_d      = active_q;
    pending_d     = pending_q;
    do_copy       = pending_q && (frame_done_d || !run);
    commit_done_d = do_copy;
    if (wr_valid && !pending_q) begin
      for (int k = 0; k < DIGITS; k++)
        if (wr_addr == 3'(k)) shadow_d[k] = wr_data;
    end
    if (do_copy) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (commit) begin
      pending_d = 1'b1;
    end
  end

  // Per-slot visibility, evaluated against the post-edge state so outputs
  // change on the same edge as slot/state.
  always_comb begin
    zero_run = 1'b1;
    supp     = '0;
    sel_data = '0;
    sel_supp = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (active_d[k][3:0] == 4'd0);
      supp[k]  = lz_suppress && zero_run && (k != 0);
    end
    for (int k = 0; k < DIGITS; k++) begin
      if (slot_d == 3'(k)) begin
        sel_data = active_d[k];
        sel_supp = supp[k];
      end
    end
`ifdef SEG_SCAN_DIM_EN
    window_lit = (int'(cnt_d) < (((int'(dim) + 1) * SHOW_LEN) / 4));
`else
    window_lit = 1'b1;
`endif
    lit = (state_d == SHOW) && window_lit && enable_mask[slot_d] &&
          !sel_data[4] && !sel_supp;
    an_d    = lit ? ~(8'd1 << slot_d) : 8'hFF;
    digit_d = lit ? sel_data[3:0] : 4'd0;
    blank_d = !lit;
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= BLANK;
      slot_q        <= 3'd0;
      cnt_q         <= '0;
      frame_done_q  <= 1'b0;
      pending_q     <= 1'b0;
      commit_done_q <= 1'b0;
      shadow_q      <= '0;
      active_q      <= '0;
      an_q          <= 8'hFF;
      digit_q       <= 4'd0;
      blank_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      cnt_q         <= cnt_d;
      frame_done_q  <= frame_done_d;
      pending_q     <= pending_d;
      commit_done_q <= commit_done_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      an_q          <= an_d;
      digit_q       <= digit_d;
      blank_q       <= blank_d;
    end
  end

  assign wr_ready    = !pending_q;
  assign commit_done = commit_done_q;
  assign frame_done  = frame_done_q;
  assign AN          = an_q;
  assign digit       = digit_q;
  assign digit_blank = blank_q;
  assign slot_idx    = slot_q;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed bench for seg_scan_scheduler (DIGITS=8, TICK_DIV=8, BLANK_CYCLES=2).
// Expected per-cycle scan outputs are queued from the directed stimulus and
// popped against the DUT one cycle at a time.
module tb_seg_scan_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [2:0] wr_addr = 3'd0;
  logic [4:0] wr_data = 5'd0;
  logic       commit = 1'b0;
  logic       commit_done;
  logic [7:0] enable_mask = 8'hFF;
  logic       lz_suppress = 1'b0;
  logic [7:0] AN;
  logic [3:0] digit;
  logic       digit_blank;
  logic [2:0] slot_idx;
  logic       frame_done;
`ifdef SEG_SCAN_DIM_EN
  logic [1:0] dim = 2'd1;
  localparam int LIT_LEN = 3;
`else
  localparam int LIT_LEN = 6;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] an;
    logic [3:0] dg;
    logic       bl;
    logic [2:0] sl;
    logic       fd;
  } exp_t;

  exp_t sb[$];

  seg_scan_scheduler #(.DIGITS(8), .TICK_DIV(8), .BLANK_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .run(run),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .commit_done(commit_done),
    .enable_mask(enable_mask), .lz_suppress(lz_suppress),
`ifdef SEG_SCAN_DIM_EN
    .dim(dim),
`endif
    .AN(AN), .digit(digit), .digit_blank(digit_blank),
    .slot_idx(slot_idx), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue one full frame of expected outputs.
  task automatic push_frame(input logic [7:0][4:0] vals, input logic [7:0] litmask,
                            input logic fd0);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 8; c++) begin
        logic on;
        on   = litmask[k] && (c >= 2) && (c - 2 < LIT_LEN);
        e.an = on ? ~(8'd1 << k) : 8'hFF;
        e.dg = on ? vals[k][3:0] : 4'd0;
        e.bl = !on;
        e.sl = 3'(k);
        e.fd = (k == 0 && c == 0) ? fd0 : 1'b0;
        sb.push_back(e);
      end
    end
  endtask

  // Pop and compare one entry per cycle, starting at the current sample.
  task automatic run_frame(input string tag);
    exp_t e, o;
    int n;
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      e = sb.pop_front();
      o = '{an: AN, dg: digit, bl: digit_blank, sl: slot_idx, fd: frame_done};
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, i, o, e);
      end
      step();
    end
  endtask

  task automatic wait_commit(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (commit_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Write all eight slots, commit, and wait for the copy.
  task automatic load(input logic [7:0][4:0] vals, input string tag);
    bit ok;
    for (int k = 0; k < 8; k++) begin
      wr_valid = 1'b1;
      wr_addr  = 3'(k);
      wr_data  = vals[k];
      step();
    end
    wr_valid = 1'b0;
    commit   = 1'b1;
    step();
    commit   = 1'b0;
    wait_commit(ok);
    chk({tag, "_commit_seen"}, 32'(ok), 32'd1);
    chk({tag, "_commit_at_wrap"}, 32'(frame_done), 32'd1);
  endtask

  logic [7:0][4:0] v;
  bit ok;
  bit bad;

  initial begin
    // Reset state
    step(); step();
    chk("rst_an", 32'(AN), 32'hFF);
    chk("rst_digit", 32'(digit), 32'd0);
    chk("rst_blank", 32'(digit_blank), 32'd1);
    chk("rst_slot", 32'(slot_idx), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_cd", 32'(commit_done), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    reset = 1'b0;

    // Slots 0..7 = 1..8, full scan frame
    for (int k = 0; k < 8; k++) v[k] = 5'(k + 1);
    load(v, "basic");
    push_frame(v, 8'hFF, 1'b1);
    run_frame("scan_basic");
    chk("frame_spacing", 32'(frame_done), 32'd1);

    // Write+commit in the same cycle, then a held write while pending
    wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 5'd9; commit = 1'b1;
    step();
    commit = 1'b0; wr_data = 5'd5;
    chk("pend_wr_ready", 32'(wr_ready), 32'd0);
    bad = 1'b0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (commit_done) begin ok = 1'b1; break; end
      if (wr_ready) bad = 1'b1;
    end
    chk("pend_done_seen", 32'(ok), 32'd1);
    chk("pend_ready_held_low", 32'(bad), 32'd0);
    chk("pend_ready_after", 32'(wr_ready), 32'd1);
    wr_valid = 1'b0;
    v[3] = 5'd9;
    push_frame(v, 8'hFF, 1'b1);
    run_frame("scan_samecycle");

    // Leading-zero suppression
    lz_suppress = 1'b1;
    v = '0; v[0] = 5'd7; v[2] = 5'd4;
    load(v, "lz");
    push_frame(v, 8'h07, 1'b1);
    run_frame("scan_lz");
    v = '0;
    load(v, "lz0");
    push_frame(v, 8'h01, 1'b1);
    run_frame("scan_lz_zero");

    // Enable mask and force-blank flag
    lz_suppress = 1'b0;
    enable_mask = 8'h0F;
    for (int k = 0; k < 8; k++) v[k] = 5'(k + 1);
    v[1] = 5'h12;
    load(v, "mask");
    push_frame(v, 8'h0D, 1'b1);
    run_frame("scan_mask");
    enable_mask = 8'hFF;

    // Reset mid-SHOW of slot 5 with a commit pending
    commit = 1'b1;
    step();
    commit = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (slot_idx == 3'd5 && AN != 8'hFF) begin ok = 1'b1; break; end
      step();
    end
    chk("reach_slot5_show", 32'(ok), 32'd1);
    chk("slot5_an", 32'(AN), 32'hDF);
    reset = 1'b1;
    step();
    chk("mid_rst_an", 32'(AN), 32'hFF);
    chk("mid_rst_digit", 32'(digit), 32'd0);
    chk("mid_rst_blank", 32'(digit_blank), 32'd1);
    chk("mid_rst_slot", 32'(slot_idx), 32'd0);
    chk("mid_rst_cd", 32'(commit_done), 32'd0);
    chk("mid_rst_wr_ready", 32'(wr_ready), 32'd1);
    reset = 1'b0;
    run   = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (AN != 8'hFF || slot_idx != 3'd0 || frame_done || commit_done) bad = 1'b1;
    end
    chk("run0_idle", 32'(bad), 32'd0);

    // Commit with run=0 copies on the very next edge
    commit = 1'b1;
    step();
    commit = 1'b0;
    chk("run0_pending", 32'(wr_ready), 32'd0);
    step();
    chk("run0_commit_lat1", 32'(commit_done), 32'd1);
    chk("run0_ready_back", 32'(wr_ready), 32'd1);
    step();

    // Restart from BLANK slot 0; buffers were cleared so every slot shows 0
    run = 1'b1;
    v = '0;
    push_frame(v, 8'hFF, 1'b0);
    run_frame("scan_restart");
    chk("restart_wrap_fd", 32'(frame_done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
